// File: rtl/rst_seq_pkg.sv
// Shared types and default constants for the staggered reset sequencer with watchdog.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        StHold,
        StStagger,
        StRun
    } seq_state_e;

    localparam int unsigned DefNumCh         = 4;
    localparam int unsigned DefHoldCycles    = 16;
    localparam int unsigned DefStaggerCycles = 4;
    localparam int unsigned DefSyncStages    = 2;
    localparam int unsigned DefWdtWidth      = 16;
    localparam int unsigned DefTimeoutResets = 0;

    // Width of a counter that must reach max(a, b) - 1.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after SYNC_STAGES clock edges.
module rst_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_no
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_no = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_wdt.sv
// Staggered multi-channel reset release sequencer with a saturating watchdog that runs
// once every channel is out of reset.
module rst_seq_wdt
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_CH         = DefNumCh,
    parameter int unsigned HOLD_CYCLES    = DefHoldCycles,
    parameter int unsigned STAGGER_CYCLES = DefStaggerCycles,
    parameter int unsigned SYNC_STAGES    = DefSyncStages,
    parameter int unsigned WDT_WIDTH      = DefWdtWidth,
    parameter int unsigned TIMEOUT_RESETS = DefTimeoutResets
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 sw_reset_i,
    output logic [NUM_CH-1:0]    ch_reset_o,
    output logic                 seq_done_o,
    input  logic                 wdt_en_i,
    input  logic                 wdt_kick_i,
    input  logic                 wdt_clear_i,
    input  logic [WDT_WIDTH-1:0] wdt_limit_i,
    output logic [WDT_WIDTH-1:0] wdt_count_o,
    output logic                 wdt_timeout_o
);

    localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CntW = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);

    logic rst_n;

    rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clk_i (clk_i),
        .rst_ni(reset_ni),
        .rst_no(rst_n)
    );

    seq_state_e            state_q;
    logic [CntW-1:0]       cnt_q;
    logic [IdxW-1:0]       idx_q;
    logic [NUM_CH-1:0]     ch_reset_q;
    logic                  seq_done_q;
    logic [WDT_WIDTH-1:0]  wdt_count_q;
    logic                  wdt_timeout_q;
    logic                  tmo_rst_q;

    logic restart;
    logic counting;
    logic at_limit;

    assign restart  = sw_reset_i | tmo_rst_q;
    assign counting = (state_q == StRun) && wdt_en_i && (wdt_limit_i != '0);
    // >= so that lowering the limit below the current count still times out.
    assign at_limit = (wdt_count_q >= wdt_limit_i);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StHold;
            cnt_q      <= '0;
            idx_q      <= '0;
            ch_reset_q <= '1;
            seq_done_q <= 1'b0;
        end else if (restart) begin
            state_q    <= StHold;
            cnt_q      <= '0;
            idx_q      <= '0;
            ch_reset_q <= '1;
            seq_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StHold: begin
                    if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
                        ch_reset_q[0] <= 1'b0;
                        cnt_q         <= '0;
                        if (NUM_CH == 1) begin
                            state_q    <= StRun;
                            seq_done_q <= 1'b1;
                        end else begin
                            state_q <= StStagger;
                            idx_q   <= IdxW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStagger: begin
                    if (cnt_q == CntW'(STAGGER_CYCLES - 1)) begin
                        ch_reset_q[idx_q] <= 1'b0;
                        cnt_q             <= '0;
                        if (idx_q == IdxW'(NUM_CH - 1)) begin
                            state_q    <= StRun;
                            seq_done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IdxW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StRun: begin
                end
                default: state_q <= StHold;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wdt_count_q   <= '0;
            wdt_timeout_q <= 1'b0;
            tmo_rst_q     <= 1'b0;
        end else begin
            tmo_rst_q <= 1'b0;
            if (restart) begin
                wdt_count_q <= '0;
            end else if (wdt_clear_i) begin
                wdt_count_q   <= '0;
                wdt_timeout_q <= 1'b0;
            end else if (wdt_kick_i) begin
                wdt_count_q <= '0;
            end else if (counting) begin
                if (at_limit) begin
                    wdt_count_q   <= wdt_limit_i;
                    wdt_timeout_q <= 1'b1;
                    // Only the 0->1 transition of the sticky flag restarts the sequence.
                    tmo_rst_q     <= (TIMEOUT_RESETS != 0) && !wdt_timeout_q;
                end else begin
                    wdt_count_q <= wdt_count_q + WDT_WIDTH'(1);
                end
            end
        end
    end

    assign ch_reset_o    = ch_reset_q;
    assign seq_done_o    = seq_done_q;
    assign wdt_count_o   = wdt_count_q;
    assign wdt_timeout_o = wdt_timeout_q;

endmodule

// File: doc/rst_seq_wdt.md
RST_SEQ_WDT -- requirements
Module: rst_seq_wdt

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of staggered reset channels (1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, cycles before channel 0 release (>=1).
REQ-003 SHALL have parameter STAGGER_CYCLES, default 4, cycles between successive channel releases (>=1).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, reset synchroniser depth (>=2).
REQ-005 SHALL have parameter WDT_WIDTH, default 16, watchdog counter width.
REQ-006 SHALL have parameter TIMEOUT_RESETS, default 0; 1 = watchdog timeout restarts the sequence.
REQ-007 SHALL have ports: clk in 1, single clock; reset_n in 1, asynchronous active-low reset; sw_reset in 1, synchronous restart pulse.
REQ-008 SHALL have ports: ch_reset out NUM_CH, active-high per-channel reset; seq_done out 1, all channels released.
REQ-009 SHALL have ports: wdt_en in 1; wdt_kick in 1; wdt_clear in 1; wdt_limit in WDT_WIDTH; wdt_count out WDT_WIDTH; wdt_timeout out 1, sticky.

Function
REQ-010 SHALL assert internal reset asynchronously on reset_n low and deassert it synchronously after SYNC_STAGES rising clk edges with reset_n high; cycle 0 = first cycle of deasserted internal reset.
REQ-011 SHALL implement FSM states HOLD, STAGGER, RUN with a shared cycle counter and a channel index.
REQ-012 HOLD: ch_reset all ones; ch_reset[0] SHALL fall at cycle HOLD_CYCLES; then STAGGER with index 1, or RUN if NUM_CH=1.
REQ-013 STAGGER: ch_reset[k] SHALL fall at cycle HOLD_CYCLES + k*STAGGER_CYCLES; released channels stay low.
REQ-014 SHALL enter RUN and raise seq_done in the same cycle ch_reset[NUM_CH-1] falls.
REQ-015 sw_reset high in any state SHALL, next cycle: ch_reset all ones, seq_done 0, state HOLD, counter 0, wdt_count 0; wdt_timeout unchanged; sw_reset beats all other inputs.
REQ-016 Watchdog SHALL count only in RUN with wdt_en=1 and wdt_limit != 0; otherwise wdt_count holds.
REQ-017 wdt_count SHALL increment by 1 per counting cycle and saturate at wdt_limit, never exceeding it or wrapping.
REQ-018 wdt_kick SHALL load wdt_count with 0 next cycle; kick beats increment and timeout detection.
REQ-019 wdt_timeout SHALL set on the cycle after wdt_count == wdt_limit with no kick while counting, and stay set until wdt_clear.
REQ-020 wdt_clear SHALL zero wdt_timeout and wdt_count next cycle; if wdt_clear and a timeout event coincide, clear wins.
REQ-021 With TIMEOUT_RESETS=1, a wdt_timeout rising edge SHALL act as sw_reset the following cycle.
REQ-022 Changing wdt_limit below the current wdt_count SHALL cause a timeout on the next counting cycle.

Reset
REQ-023 While internal reset is asserted: ch_reset all ones, seq_done 0, wdt_count 0, wdt_timeout 0, state HOLD, counters 0.
REQ-024 reset_n low mid-sequence or in RUN SHALL reassert all ch_reset asynchronously, with no glitch low on any channel.

Structure
REQ-025 Package rst_seq_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-026 Sub-module rst_sync SHALL implement the async-assert, sync-deassert synchroniser (SYNC_STAGES flops).
REQ-027 All outputs SHALL be registered.

Verification
REQ-028 Defaults, reset_n low 3 cycles then high -> ch_reset[0..3] fall at cycles 16, 20, 24, 28; seq_done rises at 28.
REQ-029 reset_n pulsed low at cycle 22 -> ch_reset = 4'b1111 immediately; after re-release, the full sequence repeats from cycle 0.
REQ-030 wdt_limit=10, wdt_en=1, no kick -> wdt_count saturates at 10; wdt_timeout rises one cycle later and stays high.
REQ-031 wdt_limit=10, kick every 8 cycles, plus one kick coincident with count=10 -> wdt_timeout never set.
REQ-032 TIMEOUT_RESETS=1, limit=5 -> after timeout, ch_reset = 4'b1111 and seq_done=0, then resequence; wdt_timeout held until wdt_clear.
REQ-033 sw_reset pulse in RUN, same cycle as wdt_kick -> next cycle ch_reset = 4'b1111 and wdt_count=0; release at 16/20/24/28.
